// File: rtl/spi_cmd_ctrl.sv
// SPI frame command controller: synchronises cs, queues 3-byte frames in a FIFO
// and executes them as tile writes, buffer fills or state/score register updates.
module spi_cmd_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int MEM_DEPTH  = 1024,
  parameter int STATE_W    = 16,
  parameter int SCORE_W    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic [7:0]         command,
  input  logic [7:0]         databyte1,
  input  logic [7:0]         databyte2,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_FILL      = 4'h2;
  localparam logic [3:0] OP_SET_STATE = 4'h3;
  localparam logic [3:0] OP_SET_SCORE = 4'h4;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FILL} fsm_t;

  logic              r_cs_s1, r_cs_s2, r_cs_s3;
  logic              w_frame_end;
  logic [23:0]       r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push, w_pop;
  logic [7:0]        r_cmd, r_db1, r_db2;
  logic [3:0]        w_opcode;
  logic [15:0]       w_word;
  fsm_t              r_fsm, w_fsm_next;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic              r_we, r_busy, r_overflow;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STATE_W-1:0] r_state;
  logic [SCORE_W-1:0] r_score;

  // Idle level of cs is high, so the synchroniser resets to 1 to avoid a phantom frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_s1 <= 1'b1;
      r_cs_s2 <= 1'b1;
      r_cs_s3 <= 1'b1;
    end else begin
      r_cs_s1 <= cs;
      r_cs_s2 <= r_cs_s1;
      r_cs_s3 <= r_cs_s2;
    end
  end

  assign w_frame_end = r_cs_s2 & ~r_cs_s3;
  assign w_pop       = (r_fsm == ST_IDLE) && (r_count != '0);
  assign w_push      = w_frame_end && ((r_count < FIFO_FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {command, databyte1, databyte2};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cmd    <= '0;
      r_db1    <= '0;
      r_db2    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        {r_cmd, r_db1, r_db2} <= r_fifo_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_opcode = r_cmd[7:4];
  assign w_word   = {r_db1, r_db2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fsm <= ST_IDLE;
    else       r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      ST_IDLE: if (r_count != '0) w_fsm_next = ST_EXEC;
      ST_EXEC: w_fsm_next = (w_opcode == OP_FILL) ? ST_FILL : ST_IDLE;
      ST_FILL: if (r_fill_cnt == FILL_LAST) w_fsm_next = ST_IDLE;
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_state    <= '0;
      r_score    <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_fill_cnt <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_fsm)
        ST_EXEC: begin
          case (w_opcode)
            OP_WRITE: begin
              r_we    <= 1'b1;
              r_waddr <= {r_cmd[ADDR_W-9:0], r_db1};
              r_wdata <= r_db2[DATA_W-1:0];
            end
            OP_FILL:      r_fill_cnt <= '0;
            OP_SET_STATE: r_state    <= w_word[STATE_W-1:0];
            OP_SET_SCORE: r_score    <= w_word[SCORE_W-1:0];
            default: ;
          endcase
        end
        ST_FILL: begin
          r_we       <= 1'b1;
          r_waddr    <= r_fill_cnt;
          r_wdata    <= r_db2[DATA_W-1:0];
          r_fill_cnt <= r_fill_cnt + 1'b1;
        end
        default: ;
      endcase
      r_busy <= (r_count != '0) || (r_fsm != ST_IDLE);
      if (w_frame_end && !w_push) r_overflow <= 1'b1;
    end
  end

  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign state    = r_state;
  assign score    = r_score;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command controller between the `spi` receiver and the frame-buffer `dpram` / `vga_top`. It detects the end of each 3-byte SPI frame (command, databyte1, databyte2) in the `clk` domain and queues frames in a small FIFO. It executes them as tile writes, full-buffer fills, or updates of the game `state` and `score` registers. It generalises the direct SPI-to-display wiring with parametrised address, data, state and score widths, configurable memory depth, queueing, and a hardware fill mode.

## Interface
- `ADDR_W`, 10: frame-buffer address width; legal range 9..12.
- `DATA_W`, 8: frame-buffer word width; legal range 1..8, taken from databyte2 LSBs.
- `MEM_DEPTH`, 1024: number of words written by FILL; must be ≤ 2^ADDR_W.
- `STATE_W`, 16: state register width; must be ≤ 16.
- `SCORE_W`, 10: score register width; must be ≤ 16.
- `FIFO_DEPTH`, 4: frame queue depth; power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock (PLL global clock).
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  raw SPI chip select, active low, asynchronous to `clk`.
- `command`  in  8  frame byte 0 from `spi`; stable while `cs` is high.
- `databyte1`  in  8  frame byte 1 from `spi`.
- `databyte2`  in  8  frame byte 2 from `spi`.
- `we`  out  1  frame-buffer write enable.
- `waddr`  out  ADDR_W  frame-buffer write address.
- `wdata`  out  DATA_W  frame-buffer write data.
- `state`  out  STATE_W  game state register, to `vga_top`.
- `score`  out  SCORE_W  score register, to `vga_top`.
- `busy`  out  1  high while the FIFO is non-empty or the FSM is not IDLE.
- `overflow`  out  1  sticky flag: a frame was dropped because the FIFO was full.

## Operation
- **Frame detection.**
  - `cs` passes through a 2-flop synchroniser (`cs_s1`, `cs_s2`) plus a history flop `cs_s3`.
  - `frame_end = cs_s2 & ~cs_s3`, i.e. a rising `cs`.
  - On `frame_end`, {command, databyte1, databyte2} is pushed into the FIFO. The bytes are sampled directly; they are stable because `sck` is idle.
- **FIFO.**
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the frame is discarded and `overflow` sets. `overflow` stays set until reset.
- **Opcode.** The opcode is `command[7:4]`:
  - 0x0 NOP: no effect.
  - 0x1 WRITE: one write with `waddr = {command[ADDR_W-9:0], databyte1}` and `wdata = databyte2[DATA_W-1:0]`.
  - 0x2 FILL: writes `databyte2[DATA_W-1:0]` to addresses 0..MEM_DEPTH-1, one per cycle, in ascending order.
  - 0x3 SET_STATE: `state <= {databyte1, databyte2}[STATE_W-1:0]`.
  - 0x4 SET_SCORE: `score <= {databyte1, databyte2}[SCORE_W-1:0]`.
  - 0x5..0xF: ignored, treated as NOP.
- **FSM states:** IDLE, EXEC, FILL.
  - IDLE: if the FIFO is non-empty, pop the head into the exec registers, then go to EXEC.
  - EXEC: decode the opcode and register the outputs.
    - WRITE: `we` = 1 for the next cycle, then IDLE.
    - SET_STATE / SET_SCORE: update the register, then IDLE.
    - FILL: load the fill counter with 0, then FILL.
    - Any other opcode: go to IDLE.
  - FILL: `we` = 1 and `waddr` = counter every cycle; the counter increments. After the write at MEM_DEPTH-1, return to IDLE with `we` = 0 in the following cycle.
- Frames arriving during FILL are queued, not lost, unless the FIFO is full.
- All outputs are registered.
- `we` is 0 in every cycle other than WRITE and FILL write cycles. `waddr`/`wdata` hold their last values when `we` = 0.

## Timing
- Reset values: `we` 0, `waddr` 0, `wdata` 0, `state` 0, `score` 0, `busy` 0, `overflow` 0. The FIFO is empty, the FSM is IDLE, and the synchroniser flops are all 1.
- Reset asserted mid-FILL or mid-queue aborts immediately; no further writes occur after reset deassertion.
- Latency, with the FIFO empty and the FSM in IDLE. Let edge 0 be the first rising `clk` that samples `cs` high:
  - push at edge 2;
  - pop at edge 3;
  - EXEC at edge 4;
  - `we` / `state` / `score` valid after edge 4.
- Throughput:
  - WRITE: one write per 2 cycles (IDLE, EXEC).
  - FILL: occupies 2 + MEM_DEPTH cycles.
- Simultaneous push and pop with a full FIFO: the push is accepted and `overflow` is unchanged.
- `busy` rises the cycle after push and falls the cycle after IDLE is re-entered with the FIFO empty.
- `cs` glitches shorter than one `clk` period may be missed. Frames must keep `cs` high for ≥ 3 `clk` cycles between frames.

## Test plan
- **WRITE.** After reset, send frame {0x12, 0x34, 0x56} with ADDR_W = 10 → exactly one `we` pulse with `waddr` = 0x234, `wdata` = 0x56, 4 cycles after `cs` is sampled high; `busy` drops afterwards.
- **SET_STATE / SET_SCORE.** Send {0x30, 0xAB, 0xCD} then {0x40, 0x03, 0xFF} → `state` = 0xABCD; `score` = 0x3FF (10-bit truncation); `we` never asserts.
- **FILL with queued writes.** Send FILL {0x20, 0x00, 0x07} with MEM_DEPTH = 1024, then 3 WRITE frames during the fill →
  - 1024 consecutive `we` cycles, addresses 0..1023, data 0x07;
  - then the 3 writes in arrival order;
  - `overflow` = 0.
- **Overflow.** With FIFO_DEPTH = 4, during FILL send 6 WRITE frames → only the first 4 execute; `overflow` = 1 and stays 1 until reset.
- **Reset mid-operation.** Assert `reset` at fill address 100 → all outputs return to their reset values at once; the FIFO is empty; no `we` after release.
- **Ignored opcodes.** Send {0x70, 0xFF, 0xFF} and {0x00, 0x11, 0x22} → no `we`, `state` and `score` unchanged, `busy` returns to 0.
